// File: rtl/sd_rsp_pkg.sv
// Shared types and constants for the SD command-response receive path.
// Pure declarations, no latency.
// No flow control of its own.
package sd_rsp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} rsp_state_e;

  localparam int RspLenShort  = 48;
  localparam int RspLenLong   = 136;
  localparam int CrcStartLong = 127;
  localparam logic [6:0] Crc7Poly = 7'h09;

  // One serial CRC7 step (x^7 + x^3 + 1), MSb-first data.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic dat);
    logic fb;
    fb = crc[6] ^ dat;
    return {crc[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
  endfunction

endpackage

// File: rtl/sd_rsp_rx_ctrl_if.sv
// Control/status bundle between the SDHCI command FSM and the response receiver.
// Wires only, no latency.
// Strobe-paced: the receiver only advances when clk_en_i is high.
interface sd_rsp_rx_ctrl_if;
  logic clk_en_i;
  logic start_i;
  logic long_rsp_i;
  logic check_crc_i;
  logic abort_i;
  logic cmd_i;
  logic sr_shift_en_o;
  logic sr_par_en_o;
  logic busy_o;
  logic done_o;
  logic timeout_o;
  logic crc_err_o;
  logic end_err_o;

  modport master (
    output clk_en_i, start_i, long_rsp_i, check_crc_i, abort_i, cmd_i,
    input  sr_shift_en_o, sr_par_en_o, busy_o, done_o, timeout_o, crc_err_o, end_err_o
  );

  modport slave (
    input  clk_en_i, start_i, long_rsp_i, check_crc_i, abort_i, cmd_i,
    output sr_shift_en_o, sr_par_en_o, busy_o, done_o, timeout_o, crc_err_o, end_err_o
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, shared by the command transmitter and response receiver.
// Result visible one clk after the absorbing strobe.
// clr wins over en; en must already be qualified by the SD clock strobe.
module sd_crc7 import sd_rsp_pkg::*; (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr,
  input  logic       en,
  input  logic       dat,
  output logic [6:0] crc
);

  // CRC register: clear on request, otherwise absorb one bit per enabled strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_step(crc, dat);
    end
  end

endmodule

// File: rtl/sd_rsp_rx_ctrl.sv
// Sequences an SD CMD-line response into an external shift register with CRC7/end-bit check.
// Start bit to done_o: Len strobes plus one clk; shift enable is combinational.
// Paced entirely by clk_en_i; abort_i forces IDLE on any cycle, strobe or not.
module sd_rsp_rx_ctrl import sd_rsp_pkg::*; #(
  parameter int TimeoutCycles = 64,
  parameter int CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input logic             clk_i,
  input logic             rst_ni,
  sd_rsp_rx_ctrl_if.slave rx
);

  localparam logic [CntWidth-1:0] TmoMax     = CntWidth'(TimeoutCycles);
  localparam logic [7:0]          FirstShort = 8'(RspLenShort - 2);
  localparam logic [7:0]          FirstLong  = 8'(RspLenLong - 2);
  localparam logic [7:0]          CrcTopLong = 8'(CrcStartLong);

  rsp_state_e          state_q, state_d;
  logic                long_q, long_d, chk_q, chk_d;
  logic [CntWidth-1:0] tmo_q, tmo_d, tmo_inc;
  logic [7:0]          bit_q, bit_d;
  logic                timeout_q, timeout_d, crc_err_q, crc_err_d;
  logic                end_err_q, end_err_d, par_en_q, par_en_d;
  logic                crc_clr, crc_upd, shift_en;
  logic [6:0]          crc;
  logic [2:0]          crc_idx;

  sd_crc7 u_crc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (crc_clr),
    .en     (rx.clk_en_i & crc_upd),
    .dat    (rx.cmd_i),
    .crc    (crc)
  );

  // The timeout counter saturates instead of wrapping.
  assign tmo_inc = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;
  // Frame bits 7..1 map onto crc[6..0].
  assign crc_idx = 3'(bit_q - 8'd1);

  // Next-state, counter, status and strobe-qualified datapath controls.
  always_comb begin
    state_d   = state_q;
    long_d    = long_q;
    chk_d     = chk_q;
    tmo_d     = tmo_q;
    bit_d     = bit_q;
    timeout_d = timeout_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    par_en_d  = par_en_q;
    crc_clr   = 1'b0;
    crc_upd   = 1'b0;
    shift_en  = 1'b0;
    if (rx.abort_i) begin
      state_d   = IDLE;
      tmo_d     = '0;
      bit_d     = '0;
      timeout_d = 1'b0;
      crc_err_d = 1'b0;
      end_err_d = 1'b0;
      par_en_d  = 1'b0;
      crc_clr   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx.start_i) begin
            long_d    = rx.long_rsp_i;
            chk_d     = rx.check_crc_i;
            tmo_d     = '0;
            timeout_d = 1'b0;
            crc_err_d = 1'b0;
            end_err_d = 1'b0;
            par_en_d  = 1'b0;
            crc_clr   = 1'b1;
            state_d   = WAIT_START;
          end
        end
        WAIT_START: begin
          if (rx.clk_en_i) begin
            if (!rx.cmd_i) begin
              shift_en = 1'b1;
              // The start bit is inside the CRC span only for short responses.
              crc_upd  = ~long_q;
              bit_d    = long_q ? FirstLong : FirstShort;
              state_d  = RECV;
            end else begin
              tmo_d = tmo_inc;
              if (tmo_inc == TmoMax) begin
                timeout_d = 1'b1;
                state_d   = DONE;
              end
            end
          end
        end
        RECV: begin
          shift_en = 1'b1;
          if (rx.clk_en_i) begin
            if (bit_q >= 8'd8 && (!long_q || bit_q <= CrcTopLong)) begin
              crc_upd = 1'b1;
            end
            if (bit_q != 8'd0 && bit_q < 8'd8 && chk_q && (rx.cmd_i != crc[crc_idx])) begin
              crc_err_d = 1'b1;
            end
            if (bit_q == 8'd0) begin
              end_err_d = ~rx.cmd_i;
              par_en_d  = 1'b1;
              state_d   = DONE;
            end else begin
              bit_d = bit_q - 8'd1;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      long_q    <= 1'b0;
      chk_q     <= 1'b0;
      tmo_q     <= '0;
      bit_q     <= '0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      long_q    <= long_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      bit_q     <= bit_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
      par_en_q  <= par_en_d;
    end
  end

  assign rx.sr_shift_en_o = shift_en;
  assign rx.sr_par_en_o   = par_en_q;
  assign rx.busy_o        = (state_q == WAIT_START) || (state_q == RECV);
  assign rx.done_o        = (state_q == DONE) && !rx.abort_i;
  assign rx.timeout_o     = timeout_q;
  assign rx.crc_err_o     = crc_err_q;
  assign rx.end_err_o     = end_err_q;

endmodule

// File: tb/tb_sd_rsp_rx_ctrl.sv
// Scoreboard bench for sd_rsp_rx_ctrl with a behavioural shift register.
// Expected responses are queued at arm time; a negedge monitor checks each done_o.
// Strobes are driven directly; there is no backpressure beyond clk_en_i pacing.
module tb_sd_rsp_rx_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_rsp_rx_ctrl_if rx();

  sd_rsp_rx_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx     (rx)
  );

  typedef struct {
    logic         tmo;
    logic         crc;
    logic         endb;
    logic         par;
    int           strobes;
    int           shifts;
    logic         chk_dat;
    logic [135:0] dat;
    int           len;
    int           sbase;
    int           shbase;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           done_cnt = 0;
  int           strobe_cnt = 0;
  int           shift_cnt = 0;
  logic [135:0] sr = '0;

  logic [135:0] f_ok    = 136'h40_0000_0000_95;
  logic [135:0] f_crc   = 136'h40_0000_0000_97;
  logic [135:0] f_end   = 136'h40_0000_0000_94;
  logic [135:0] f_l_ok  = 136'h3F_0000_0000_0000_0000_0000_40_0000_0000_95;
  logic [135:0] f_l_crc = 136'h3F_0000_0000_0000_0000_0000_40_0000_0000_97;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b want=%0b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: models the external shift register, counts strobes, scores each done_o.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rx.clk_en_i && rx.busy_o) strobe_cnt++;
        if (rx.clk_en_i && rx.sr_shift_en_o) begin
          shift_cnt++;
          sr = {sr[134:0], rx.cmd_i};
        end
        if (rx.done_o) begin
          done_cnt++;
          if (q.size() == 0) begin
            chk_b("unexpected_done", rx.done_o, 1'b0);
          end else begin
            mon_e = q.pop_front();
            chk_b("timeout", rx.timeout_o, mon_e.tmo);
            chk_b("crc_err", rx.crc_err_o, mon_e.crc);
            chk_b("end_err", rx.end_err_o, mon_e.endb);
            chk_b("par_en", rx.sr_par_en_o, mon_e.par);
            chk_i("strobes", strobe_cnt - mon_e.sbase, mon_e.strobes);
            chk_i("shifts", shift_cnt - mon_e.shbase, mon_e.shifts);
            if (mon_e.chk_dat) begin
              if (mon_e.len == 48) chk_w("sr_short", {88'h0, sr[47:0]}, mon_e.dat);
              else                 chk_w("sr_long", sr, mon_e.dat);
            end
          end
        end
      end
    end
  end

  task automatic expect_rsp(input logic tmo, input logic crc, input logic endb, input logic par,
                            input int strobes, input int shifts, input logic chk_dat,
                            input logic [135:0] dat, input int len);
    exp_t e;
    e.tmo = tmo; e.crc = crc; e.endb = endb; e.par = par;
    e.strobes = strobes; e.shifts = shifts; e.chk_dat = chk_dat;
    e.dat = dat; e.len = len; e.sbase = strobe_cnt; e.shbase = shift_cnt;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic b, input int sp);
    rx.cmd_i = b;
    for (int i = 0; i < sp; i++) begin
      rx.clk_en_i = (i == sp - 1);
      @(posedge clk);
      #1;
    end
    rx.clk_en_i = 1'b0;
    rx.cmd_i = 1'b1;
  endtask

  task automatic arm(input logic lng, input logic cc);
    rx.start_i = 1'b1;
    rx.long_rsp_i = lng;
    rx.check_crc_i = cc;
    cyc(1);
    rx.start_i = 1'b0;
    rx.long_rsp_i = 1'b0;
    rx.check_crc_i = 1'b0;
  endtask

  task automatic send(input logic [135:0] f, input int hi, input int lo, input int sp);
    for (int i = hi; i >= lo; i--) strobe(f[i], sp);
  endtask

  task automatic wait_done(input int tgt);
    for (int k = 0; k < 40 && done_cnt < tgt; k++) cyc(1);
    cyc(1);
    chk_i("done_count", done_cnt, tgt);
  endtask

  task automatic run_frame(input logic lng, input logic cc, input logic [135:0] f, input int sp,
                           input logic crc, input logic endb);
    int len;
    int tgt;
    len = lng ? 136 : 48;
    tgt = done_cnt + 1;
    expect_rsp(1'b0, crc, endb, 1'b1, len + 3, len, 1'b1, f, len);
    arm(lng, cc);
    repeat (3) strobe(1'b1, sp);
    send(f, len - 1, 0, sp);
    wait_done(tgt);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tgt;
    rx.clk_en_i = 1'b0; rx.start_i = 1'b0; rx.long_rsp_i = 1'b0;
    rx.check_crc_i = 1'b0; rx.abort_i = 1'b0; rx.cmd_i = 1'b1;
    #2;
    chk_b("rst_shift", rx.sr_shift_en_o, 1'b0);
    chk_b("rst_par", rx.sr_par_en_o, 1'b0);
    chk_b("rst_busy", rx.busy_o, 1'b0);
    chk_b("rst_done", rx.done_o, 1'b0);
    chk_b("rst_tmo", rx.timeout_o, 1'b0);
    chk_b("rst_crc", rx.crc_err_o, 1'b0);
    chk_b("rst_end", rx.end_err_o, 1'b0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Short frame, good CRC and end bit.
    run_frame(1'b0, 1'b1, f_ok, 1, 1'b0, 1'b0);
    chk_b("par_held_idle", rx.sr_par_en_o, 1'b1);

    // Bad CRC byte, checked and unchecked.
    run_frame(1'b0, 1'b1, f_crc, 1, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, f_crc, 1, 1'b0, 1'b0);

    // No start bit: timeout on the 64th strobe.
    tgt = done_cnt + 1;
    expect_rsp(1'b1, 1'b0, 1'b0, 1'b0, 64, 0, 1'b0, '0, 48);
    arm(1'b0, 1'b1);
    chk_b("par_cleared_by_start", rx.sr_par_en_o, 1'b0);
    repeat (64) strobe(1'b1, 1);
    wait_done(tgt);
    chk_b("tmo_par_idle", rx.sr_par_en_o, 1'b0);

    // Bad end bit.
    run_frame(1'b0, 1'b1, f_end, 1, 1'b0, 1'b1);

    // R2 long frame, dense and 1-in-4 strobes, plus a bad CRC.
    run_frame(1'b1, 1'b1, f_l_ok, 1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, f_l_ok, 4, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, f_l_crc, 1, 1'b1, 1'b0);

    // Abort at bit 20: back to idle, flags and par_en cleared, no done_o.
    tgt = done_cnt;
    arm(1'b0, 1'b1);
    repeat (3) strobe(1'b1, 1);
    send(f_ok, 47, 28, 1);
    chk_b("busy_before_abort", rx.busy_o, 1'b1);
    rx.abort_i = 1'b1;
    cyc(1);
    rx.abort_i = 1'b0;
    chk_b("abort_busy", rx.busy_o, 1'b0);
    chk_b("abort_par", rx.sr_par_en_o, 1'b0);
    cyc(10);
    chk_i("abort_no_done", done_cnt, tgt);

    // Start and abort together: abort wins.
    rx.start_i = 1'b1;
    rx.abort_i = 1'b1;
    cyc(1);
    rx.start_i = 1'b0;
    rx.abort_i = 1'b0;
    chk_b("start_abort_busy", rx.busy_o, 1'b0);
    strobe(1'b0, 1);
    chk_b("start_abort_still_idle", rx.busy_o, 1'b0);

    // start_i during RECV is ignored; the short frame completes normally.
    tgt = done_cnt + 1;
    expect_rsp(1'b0, 1'b0, 1'b0, 1'b1, 51, 48, 1'b1, f_ok, 48);
    arm(1'b0, 1'b1);
    repeat (3) strobe(1'b1, 1);
    send(f_ok, 47, 38, 1);
    arm(1'b1, 1'b0);
    send(f_ok, 37, 0, 1);
    wait_done(tgt);

    // Async reset at bit 30.
    tgt = done_cnt;
    arm(1'b0, 1'b1);
    repeat (3) strobe(1'b1, 1);
    send(f_ok, 47, 18, 1);
    chk_b("busy_before_reset", rx.busy_o, 1'b1);
    rx.clk_en_i = 1'b1;
    rx.cmd_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_b("arst_busy", rx.busy_o, 1'b0);
    chk_b("arst_shift", rx.sr_shift_en_o, 1'b0);
    chk_b("arst_par", rx.sr_par_en_o, 1'b0);
    chk_b("arst_done", rx.done_o, 1'b0);
    rx.clk_en_i = 1'b0;
    rx.cmd_i = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk_i("arst_no_done", done_cnt, tgt);

    chk_i("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
